// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the CPU pipeline.
//   lsu_state_t   : MEM-stage load/store unit FSM states
//   mem_size_t    : access size encoding carried in ex_mem_mem_data_mask
//   is_misaligned : true when an access crosses its natural alignment
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef logic [1:0] mem_size_t;

    localparam mem_size_t MEM_BYTE = 2'b00;
    localparam mem_size_t MEM_HALF = 2'b01;
    localparam mem_size_t MEM_WORD = 2'b10;   // 2'b11 is also treated as a word

    // Bytes are always aligned; halves need addr[0]=0; words need addr[1:0]=00.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = addr_lo[0];
            default:  mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for the load/store unit.
// Ports:
//   size       in  2   access size (MEM_BYTE / MEM_HALF / MEM_WORD, 11 = word)
//   addr_lo    in  2   low address bits selecting the byte lane
//   zero_ext   in  1   1 = zero-extend loads, 0 = sign-extend
//   store_data in  32  right-justified store data
//   rdata      in  32  word returned by the data bus
//   wstrb      out 4   byte strobes for a store of this size/lane
//   wdata      out 32  store data replicated across all lanes
//   load_ext   out 32  selected lane, extended to 32 bits
// -----------------------------------------------------------------------------
module lsu_lane_align
    import cpu_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  addr_lo,
    input  logic        zero_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Half accesses use addr[1] only, so an odd half address aligns down.
    assign ld_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign ld_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        wstrb    = 4'b1111;
        wdata    = store_data;
        load_ext = rdata;
        case (size)
            MEM_BYTE: begin
                wstrb    = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
                load_ext = zero_ext ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            MEM_HALF: begin
                wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{store_data[15:0]}};
                load_ext = zero_ext ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// MEM-stage load/store unit. Consumes the EX/MEM register fields, runs one
// valid/ready request plus one response per instruction on the data bus,
// returns the extended load value and stalls the front of the pipe until the
// access completes (IDLE -> REQ -> RESP -> DONE, DONE releases stall once).
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in REQ+RESP before abort with bus_err (0 = off)
//   CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  misaligned half/word accesses are not issued; the
//                         unit goes IDLE -> DONE and pulses misaligned.
//                         Undefined: misaligned is tied 0, accesses align down.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   ex_mem_alu_result     in  32    access byte address
//   ex_mem_mem_read/write in  1     load / store request (write wins)
//   ex_mem_mem_data_mask  in  2     size: 00 byte, 01 half, 1x word
//   ex_mem_mem_unsigned   in  1     zero-extend the load
//   ex_mem_mem_write_data in  32    right-justified store data
//   dbus_req_*                      request channel (valid/ready, we, addr, wstrb, wdata)
//   dbus_rsp_valid/rdata  in        response channel
//   stall                 out 1     hold IF..EX/MEM this cycle
//   load_data             out 32    last completed load, extended
//   bus_err               out 1     one-cycle pulse on timeout abort
//   misaligned            out 1     one-cycle pulse on trapped access
// -----------------------------------------------------------------------------
module mem_stage_lsu
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_mem_alu_result,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic [1:0]  ex_mem_mem_data_mask,
    input  logic        ex_mem_mem_unsigned,
    input  logic [31:0] ex_mem_mem_write_data,
    output logic        dbus_req_valid,
    input  logic        dbus_req_ready,
    output logic        dbus_req_we,
    output logic [31:0] dbus_req_addr,
    output logic [3:0]  dbus_req_wstrb,
    output logic [31:0] dbus_req_wdata,
    input  logic        dbus_rsp_valid,
    input  logic [31:0] dbus_rsp_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        bus_err,
    output logic        misaligned
);

    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST   =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             access;
    logic             misalign_hit;
    logic             timeout_hit;
    logic             rsp_take;
    logic [3:0]       lane_wstrb;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_load;

    assign access = ex_mem_mem_read | ex_mem_mem_write;

    // Abort when the last allowed REQ/RESP cycle is reached, so exactly
    // TIMEOUT_CYCLES cycles are spent waiting on the bus.
    assign timeout_hit = TIMEOUT_EN && ((state == REQ) || (state == RESP)) && (cnt == CNT_LAST);

    // A response in the timeout cycle still completes the access.
    assign rsp_take = (state == RESP) && dbus_rsp_valid;

    // EX/MEM is frozen by stall for the whole transaction, so the live size,
    // lane and sign fields are still valid when the response returns.
    lsu_lane_align u_lane_align (
        .size       (ex_mem_mem_data_mask),
        .addr_lo    (ex_mem_alu_result[1:0]),
        .zero_ext   (ex_mem_mem_unsigned),
        .store_data (ex_mem_mem_write_data),
        .rdata      (dbus_rsp_rdata),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .load_ext   (lane_load)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign misalign_hit = is_misaligned(ex_mem_mem_data_mask, ex_mem_alu_result[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= (state == IDLE) && access && misalign_hit;
    end

    assign misaligned = mis_q;
`else
    assign misalign_hit = 1'b0;
    assign misaligned   = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        stall          = 1'b0;
        dbus_req_valid = 1'b0;
        case (state)
            IDLE: begin
                // Stall in the same cycle the access appears in EX/MEM.
                if (access) begin
                    stall      = 1'b1;
                    state_next = misalign_hit ? DONE : REQ;
                end
            end
            REQ: begin
                stall          = 1'b1;
                dbus_req_valid = !timeout_hit;
                if (timeout_hit)         state_next = DONE;
                else if (dbus_req_ready) state_next = RESP;
            end
            RESP: begin
                stall = 1'b1;
                if (rsp_take || timeout_hit) state_next = DONE;
            end
            // One unstalled cycle lets EX/MEM advance before a new access is seen.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            dbus_req_we    <= 1'b0;
            dbus_req_addr  <= '0;
            dbus_req_wstrb <= '0;
            dbus_req_wdata <= '0;
            load_data      <= '0;
            bus_err        <= 1'b0;
        end else begin
            state   <= state_next;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !misalign_hit) begin
                        cnt            <= '0;
                        dbus_req_we    <= ex_mem_mem_write;
                        dbus_req_addr  <= {ex_mem_alu_result[31:2], 2'b00};
                        dbus_req_wstrb <= ex_mem_mem_write ? lane_wstrb : 4'b0000;
                        dbus_req_wdata <= lane_wdata;
                    end
                end
                REQ, RESP: begin
                    cnt <= cnt + 1'b1;
                    if (rsp_take) begin
                        if (!dbus_req_we) load_data <= lane_load;
                    end else if (timeout_hit) begin
                        bus_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed bench for mem_stage_lsu. u_dut uses the default timeout; u_dut_to
// uses TIMEOUT_CYCLES=4 for abort and response-vs-timeout cases. Expected bus
// requests and load results go into scoreboard queues when stimulus is driven
// and are popped when the DUT handshakes / completes.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_mem_alu_result;
    logic        ex_mem_mem_read;
    logic        ex_mem_mem_write;
    logic [1:0]  ex_mem_mem_data_mask;
    logic        ex_mem_mem_unsigned;
    logic [31:0] ex_mem_mem_write_data;
    logic        dbus_req_valid, dbus_req_ready, dbus_req_we;
    logic [31:0] dbus_req_addr, dbus_req_wdata;
    logic [3:0]  dbus_req_wstrb;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rsp_rdata;
    logic        stall, bus_err, misaligned;
    logic [31:0] load_data;

    logic        to_read, to_write, to_ready, to_rsp_valid;
    logic        to_req_valid, to_req_we, to_stall, to_bus_err, to_misaligned;
    logic [31:0] to_req_addr, to_req_wdata, to_load_data;
    logic [3:0]  to_req_wstrb;

    always #5 clk = ~clk;

    mem_stage_lsu u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .ex_mem_alu_result     (ex_mem_alu_result),
        .ex_mem_mem_read       (ex_mem_mem_read),
        .ex_mem_mem_write      (ex_mem_mem_write),
        .ex_mem_mem_data_mask  (ex_mem_mem_data_mask),
        .ex_mem_mem_unsigned   (ex_mem_mem_unsigned),
        .ex_mem_mem_write_data (ex_mem_mem_write_data),
        .dbus_req_valid        (dbus_req_valid),
        .dbus_req_ready        (dbus_req_ready),
        .dbus_req_we           (dbus_req_we),
        .dbus_req_addr         (dbus_req_addr),
        .dbus_req_wstrb        (dbus_req_wstrb),
        .dbus_req_wdata        (dbus_req_wdata),
        .dbus_rsp_valid        (dbus_rsp_valid),
        .dbus_rsp_rdata        (dbus_rsp_rdata),
        .stall                 (stall),
        .load_data             (load_data),
        .bus_err               (bus_err),
        .misaligned            (misaligned)
    );

    mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u_dut_to (
        .clk                   (clk),
        .rst                   (rst),
        .ex_mem_alu_result     (ex_mem_alu_result),
        .ex_mem_mem_read       (to_read),
        .ex_mem_mem_write      (to_write),
        .ex_mem_mem_data_mask  (ex_mem_mem_data_mask),
        .ex_mem_mem_unsigned   (ex_mem_mem_unsigned),
        .ex_mem_mem_write_data (ex_mem_mem_write_data),
        .dbus_req_valid        (to_req_valid),
        .dbus_req_ready        (to_ready),
        .dbus_req_we           (to_req_we),
        .dbus_req_addr         (to_req_addr),
        .dbus_req_wstrb        (to_req_wstrb),
        .dbus_req_wdata        (to_req_wdata),
        .dbus_rsp_valid        (to_rsp_valid),
        .dbus_rsp_rdata        (dbus_rsp_rdata),
        .stall                 (to_stall),
        .load_data             (to_load_data),
        .bus_err               (to_bus_err),
        .misaligned            (to_misaligned)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_exp_t;

    req_exp_t    req_q[$];
    logic [31:0] ld_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    // One access on u_dut, starting and ending at a negedge with the FSM idle.
    task automatic do_access(
        input string tag, input logic rd, input logic wr, input logic [31:0] addr,
        input logic [1:0] size, input logic uns, input logic [31:0] wd, input logic [31:0] rdata,
        input int ready_dly, input int rsp_dly, input logic rsp_noise, input logic issue,
        input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_wstrb,
        input logic [31:0] e_wdata, input logic [31:0] e_ld, input int e_stall, input logic e_mis);
        int   cyc    = 0;
        int   stalls = 0;
        int   rw     = ready_dly;
        int   sw     = rsp_dly;
        logic in_resp = 1'b0;
        logic done    = 1'b0;
        req_exp_t e;

        #1 check({tag, "_idle_stall"}, 32'(stall), 32'd0);
        if (issue) req_q.push_back('{e_addr, e_we, e_wstrb, e_wdata});
        ld_q.push_back(e_ld);
        ex_mem_alu_result     = addr;
        ex_mem_mem_data_mask  = size;
        ex_mem_mem_unsigned   = uns;
        ex_mem_mem_write_data = wd;
        ex_mem_mem_read       = rd;
        ex_mem_mem_write      = wr;
        dbus_rsp_rdata        = rdata;

        while (!done && cyc < 60) begin
            dbus_req_ready = (rw == 0);
            dbus_rsp_valid = in_resp ? (sw == 0) : rsp_noise;
            #1;
            if (stall) stalls++;
            if (dbus_req_valid) begin
                check({tag, "_req_expected"}, 32'(req_q.size() > 0), 32'd1);
                if (req_q.size() > 0) begin
                    e = req_q[0];
                    check({tag, "_addr"},  dbus_req_addr, e.addr);
                    check({tag, "_we"},    32'(dbus_req_we), 32'(e.we));
                    check({tag, "_wstrb"}, 32'(dbus_req_wstrb), 32'(e.wstrb));
                    check({tag, "_wdata"}, dbus_req_wdata, e.wdata);
                    if (dbus_req_ready) begin
                        void'(req_q.pop_front());
                        in_resp = 1'b1;
                    end
                end
                if (rw > 0) rw--;
            end else if (in_resp && sw > 0) begin
                sw--;
            end
            if (!stall) begin
                done = 1'b1;
                check({tag, "_stall_cycles"}, stalls, e_stall);
                check({tag, "_load_data"}, load_data, ld_q.pop_front());
                check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
                check({tag, "_misaligned"}, 32'(misaligned), 32'(e_mis));
                check({tag, "_req_consumed"}, 32'(req_q.size()), 32'd0);
                ex_mem_mem_read  = 1'b0;
                ex_mem_mem_write = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
        dbus_req_ready = 1'b0;
        dbus_rsp_valid = 1'b0;
        #1 check({tag, "_mis_pulse_end"}, 32'(misaligned), 32'd0);
    endtask

    // One word load on u_dut_to; rsp_at is the cycle index (0 = IDLE) of the
    // single response pulse, -1 for none.
    task automatic run_to(input string tag, input int rsp_at, input logic [31:0] rdata,
                          input int e_stall, input logic e_err, input logic [31:0] e_ld);
        int   k      = 0;
        int   stalls = 0;
        logic done   = 1'b0;

        ld_q.push_back(e_ld);
        ex_mem_alu_result    = 32'h0000_9000;
        ex_mem_mem_data_mask = MEM_WORD;
        ex_mem_mem_unsigned  = 1'b0;
        dbus_rsp_rdata       = rdata;
        to_ready             = 1'b1;
        to_read              = 1'b1;
        while (!done && k < 30) begin
            to_rsp_valid = (k == rsp_at);
            #1;
            if (to_stall) stalls++;
            else begin
                done = 1'b1;
                check({tag, "_stall_cycles"}, stalls, e_stall);
                check({tag, "_bus_err"}, 32'(to_bus_err), 32'(e_err));
                check({tag, "_req_valid"}, 32'(to_req_valid), 32'd0);
                check({tag, "_load_data"}, to_load_data, ld_q.pop_front());
                to_read = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
        to_rsp_valid = 1'b0;
        to_ready     = 1'b0;
        #1 check({tag, "_err_pulse_end"}, 32'(to_bus_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ex_mem_alu_result = '0; ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0;
        ex_mem_mem_data_mask = MEM_BYTE; ex_mem_mem_unsigned = 1'b0;
        ex_mem_mem_write_data = '0; dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0;
        dbus_rsp_rdata = '0;
        to_read = 1'b0; to_write = 1'b0; to_ready = 1'b0; to_rsp_valid = 1'b0;

        #1;
        check("rst_req_valid", 32'(dbus_req_valid), 32'd0);
        check("rst_req_we",    32'(dbus_req_we), 32'd0);
        check("rst_req_addr",  dbus_req_addr, 32'd0);
        check("rst_req_wstrb", 32'(dbus_req_wstrb), 32'd0);
        check("rst_req_wdata", dbus_req_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_bus_err",   32'(bus_err), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_stall",     32'(stall), 32'd0);
        check("rst_to_outputs", {to_req_addr[31:2] | to_req_wdata[31:2],
                                 to_req_wstrb[1] | to_req_wstrb[0] | to_req_wstrb[2] | to_req_wstrb[3] | to_req_we,
                                 to_req_valid | to_misaligned | (|to_load_data) | to_bus_err | to_stall},
              32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        //         tag       rd wr addr          size      uns wd            rdata         rdy rsp nz iss  e_addr        we e_wstrb  e_wdata       e_ld          st mis
        do_access("lb_s",    1, 0, 32'h0000_1003, MEM_BYTE, 0, 32'h0,        32'h80FF_FF12, 0, 0, 1, 1, 32'h0000_1000, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 3, 0);
        do_access("sh",      0, 1, 32'h0000_2002, MEM_HALF, 0, 32'h0000_BEEF, 32'h0,       0, 0, 0, 1, 32'h0000_2000, 1, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FF80, 3, 0);
        do_access("lw_wait", 1, 0, 32'h0000_4008, MEM_WORD, 0, 32'h0,        32'h1234_5678, 5, 0, 0, 1, 32'h0000_4008, 0, 4'b0000, 32'h0,        32'h1234_5678, 8, 0);
        do_access("lhu",     1, 0, 32'h0000_5002, MEM_HALF, 1, 32'h0,        32'h8001_7FFF, 0, 3, 0, 1, 32'h0000_5000, 0, 4'b0000, 32'h0,        32'h0000_8001, 6, 0);
        do_access("lh_s",    1, 0, 32'h0000_5000, MEM_HALF, 0, 32'h0,        32'h7FFF_8001, 0, 0, 0, 1, 32'h0000_5000, 0, 4'b0000, 32'h0,        32'hFFFF_8001, 3, 0);
        do_access("lbu",     1, 0, 32'h0000_5001, MEM_BYTE, 1, 32'h0,        32'hAABB_CCDD, 0, 0, 0, 1, 32'h0000_5000, 0, 4'b0000, 32'h0,        32'h0000_00CC, 3, 0);
        do_access("sb",      0, 1, 32'h0000_6001, MEM_BYTE, 0, 32'h1234_56A5, 32'h0,       0, 0, 0, 1, 32'h0000_6000, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_00CC, 3, 0);
        do_access("sw_rdwr", 1, 1, 32'h0000_7000, 2'b11,    0, 32'hDEAD_BEEF, 32'h1111_1111, 0, 0, 0, 1, 32'h0000_7000, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_00CC, 3, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_access("lw_mis",  1, 0, 32'h0000_3001, MEM_WORD, 0, 32'h0,        32'hCAFE_0001, 0, 0, 0, 0, 32'h0,         0, 4'b0000, 32'h0,        32'h0000_00CC, 1, 1);
`else
        do_access("lw_mis",  1, 0, 32'h0000_3001, MEM_WORD, 0, 32'h0,        32'hCAFE_0001, 0, 0, 0, 1, 32'h0000_3000, 0, 4'b0000, 32'h0,        32'hCAFE_0001, 3, 0);
`endif

        // Timeout instance: normal load, abort with no response, then a
        // response landing in the timeout cycle.
        run_to("to_ok",    2,  32'h0BAD_F00D, 3, 1'b0, 32'h0BAD_F00D);
        run_to("to_abort", -1, 32'h5555_5555, 5, 1'b1, 32'h0BAD_F00D);
        run_to("to_race",  4,  32'h6666_6666, 5, 1'b0, 32'h6666_6666);

        // Reset while waiting in RESP; a late response after release is ignored.
        ex_mem_alu_result = 32'h0000_8000; ex_mem_mem_data_mask = MEM_WORD;
        ex_mem_mem_write_data = 32'h0; ex_mem_mem_read = 1'b1;
        dbus_req_ready = 1'b1; dbus_rsp_valid = 1'b0; dbus_rsp_rdata = 32'h7777_7777;
        @(negedge clk);
        @(negedge clk);
        #1 check("rstresp_pre_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        ex_mem_mem_read = 1'b0;
        #1;
        check("rstresp_stall", 32'(stall), 32'd0);
        check("rstresp_load_data", load_data, 32'd0);
        #2 rst = 1'b0;
        dbus_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rstresp_post_stall", 32'(stall), 32'd0);
            check("rstresp_post_valid", 32'(dbus_req_valid), 32'd0);
            check("rstresp_post_load",  load_data, 32'd0);
        end
        dbus_rsp_valid = 1'b0;
        dbus_req_ready = 1'b0;

        // Reset while REQ is outstanding drops the request immediately.
        @(negedge clk);
        ex_mem_mem_read = 1'b1;
        @(negedge clk);
        #1 check("rstreq_pre_valid", 32'(dbus_req_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rstreq_valid", 32'(dbus_req_valid), 32'd0);
        check("rstreq_addr",  dbus_req_addr, 32'd0);
        ex_mem_mem_read = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        #1 check("rstreq_post_stall", 32'(stall), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
